shift_add_multiplier: RTL and testbench
=======================================

# shift_add_multiplier

Sequential unsigned multiplier built around one shared N-bit ripple adder (`Full_Adder_N`, add mode, `C_in_i`=0). A small FSM drives the adder once per cycle for REGISTER_WIDTH cycles. Each cycle is a conditional add followed by a right shift into a 2N-bit product register. It is the CPU's multi-cycle MUL unit. It sits beside the ALU and is driven by the control unit through a start/done handshake.

## Interface
- REGISTER_WIDTH, 8, operand width N (≥2); product is 2N bits
- clk_i  input  1  single clock, all state updates on rising edge
- rst_n_i  input  1  asynchronous, active-low reset
- start_i  input  1  request; accepted only when ready_o=1
- A_i  input  N  multiplicand, sampled on the accepting edge
- B_i  input  N  multiplier, sampled on the accepting edge
- ready_o  output  1  high in IDLE only
- busy_o  output  1  high in CALC only
- done_o  output  1  one-cycle pulse, high in DONE only
- P_o  output  2N  product {HI,LO}; valid from DONE until the next accepted start

## Operation
- Internal registers:
  - M (N), multiplicand copy
  - HI (N), upper accumulator
  - LO (N), multiplier that becomes the product's lower half
  - CNT, counter of $clog2(N)+1 bits
- P_o is driven directly as {HI,LO}.
- Adder inputs: A=HI, B=(LO[0] ? M : 0), C_in=0. The carry used is C_out_o[N-1], called Cn.
- States:
  - IDLE: ready_o=1. When start_i=1: M←A_i, HI←0, LO←B_i, CNT←0, go to CALC. Otherwise hold all registers.
  - CALC: busy_o=1. Each cycle: {HI,LO}←{Cn, SUM, LO[N-1:1]}, where SUM is the adder sum, and CNT←CNT+1. When CNT=N-1 (the Nth iteration), go to DONE.
  - DONE: done_o=1, registers hold, go to IDLE unconditionally.
- start_i is ignored in CALC and DONE. It is not queued, and A_i/B_i changes there have no effect.
- Arithmetic is unsigned. The result is exact, P_o = A_i×B_i, with no overflow possible in 2N bits. The adder carry-out is captured into HI's MSB every iteration, so no carry is lost (e.g. 0xFF×0xFF).
- Operands of 0 behave normally: the full N iterations run and the product is 0. There is no early termination.
- Reset mid-operation: the FSM returns to IDLE immediately and all registers clear. No done_o pulse occurs for the aborted operation.

## Timing
- Reset values: state=IDLE, ready_o=1, busy_o=0, done_o=0, P_o=0, M=0, CNT=0.
- Start accepted at edge t0 (start_i=1 and ready_o=1 before the edge).
- CALC lasts N cycles (edges t0+1..t0+N). The state is DONE after edge t0+N.
- done_o=1 and P_o valid during the cycle after edge t0+N. Latency from accepting edge to done_o high is N cycles; 8 cycles for N=8.
- ready_o returns high one cycle after done_o.
- Minimum initiation interval is N+2 cycles: IDLE accept, N CALC cycles, DONE.
- P_o changes on every CALC edge; intermediate values are not meaningful. It holds through DONE and IDLE until the next accepted start, at which point HI←0 and LO←B_i.
- All outputs are decoded from registered state; there are no combinational paths from start_i or A_i/B_i to any output.
- The adder path is HI→SUM→HI and must close in one cycle.

## Test plan
- Reset, then A=13, B=11, start one cycle. Required: busy_o high for 8 cycles, then done_o for exactly 1 cycle with P_o=0x008F (143), then ready_o=1.
- A=0xFF, B=0xFF. Required: P_o=0xFE01 at done_o; this exercises carry capture every iteration.
- A=0x00, B=0xA5, then A=0xA5, B=0x00. Required: P_o=0 each time, with the full 8-cycle busy period and a done_o pulse each time.
- Start with A=3, B=5, then hold start_i=1 with A=7, B=7 throughout CALC and DONE. Required: first done_o gives P_o=15. A second operation is accepted only in the following IDLE cycle and yields 49.
- Start A=200, B=100, assert rst_n_i low asynchronously mid-cycle at iteration 4. Required: immediate P_o=0, done_o=0, ready_o=1, and no done_o pulse afterward. After release, 6×7 gives 42.
- Back-to-back: assert start_i in the first IDLE cycle after done_o with A=0x80, B=0x02. Required: accepted with no extra gap; P_o=0x0100 after 8 CALC cycles.

Source files
------------

// File: rtl/shift_add_multiplier.sv
// N-bit ripple-carry adder with per-bit carry outputs; combinational, no backpressure.
// When sub_i=1, B is inverted. Drive C_in_i=1 as well to get A-B.
module Full_Adder_N #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             C_in_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] S_o,
    output logic [WIDTH-1:0] C_out_o
);

    logic [WIDTH:0] carry;

    assign carry[0] = C_in_i;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic b_eff;
        assign b_eff      = B_i[i] ^ sub_i;
        assign S_o[i]     = A_i[i] ^ b_eff ^ carry[i];
        assign carry[i+1] = (A_i[i] & b_eff) | (carry[i] & (A_i[i] ^ b_eff));
        assign C_out_o[i] = carry[i+1];
    end

endmodule

// Sequential unsigned multiplier: one conditional add and right shift per cycle, N iterations.
// Latency N cycles from accept to done_o; start_i is taken only while ready_o, never queued.
module shift_add_multiplier #(
    parameter int REGISTER_WIDTH = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        start_i,
    input  logic [REGISTER_WIDTH-1:0]   A_i,
    input  logic [REGISTER_WIDTH-1:0]   B_i,
    output logic                        ready_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [2*REGISTER_WIDTH-1:0] P_o
);

    localparam int N  = REGISTER_WIDTH;
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [N-1:0]   m_reg;
    logic [N-1:0]   hi;
    logic [N-1:0]   lo;
    logic [CW-1:0]  cnt;

    logic [N-1:0]   addend;
    logic [N-1:0]   sum;
    logic [N-1:0]   carry;
    logic           cn;
    logic           last_iter;
    logic           unused_carry;

    assign addend    = lo[0] ? m_reg : '0;
    assign cn        = carry[N-1];
    assign last_iter = (cnt == LAST);

    // Only the final carry feeds the product; the lower carries are internal to the adder.
    assign unused_carry = ^carry[N-2:0];

    Full_Adder_N #(
        .WIDTH (N)
    ) u_adder (
        .A_i     (hi),
        .B_i     (addend),
        .C_in_i  (1'b0),
        .sub_i   (1'b0),
        .S_o     (sum),
        .C_out_o (carry)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = CALC;
            CALC:    if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            m_reg <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        m_reg <= A_i;
                        hi    <= '0;
                        lo    <= B_i;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    // Carry-out becomes HI's MSB so no bit of the partial sum is lost.
                    hi  <= {cn, sum[N-1:1]};
                    lo  <= {sum[0], lo[N-1:1]};
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ready_o = (state == IDLE);
    assign busy_o  = (state == CALC);
    assign done_o  = (state == DONE);
    assign P_o     = {hi, lo};

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed and random checks of shift_add_multiplier against a plain a*b reference.
module tb_shift_add_multiplier;

    localparam int N = 8;

    logic           clk_i;
    logic           rst_n_i;
    logic           start_i;
    logic [N-1:0]   A_i;
    logic [N-1:0]   B_i;
    logic           ready_o;
    logic           busy_o;
    logic           done_o;
    logic [2*N-1:0] P_o;

    int checks = 0;
    int errors = 0;

    shift_add_multiplier #(
        .REGISTER_WIDTH (N)
    ) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .start_i (start_i),
        .A_i     (A_i),
        .B_i     (B_i),
        .ready_o (ready_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .P_o     (P_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*N-1:0] ref_mul(input int unsigned a, input int unsigned b);
        int unsigned p;
        p = a * b;
        return p[2*N-1:0];
    endfunction

    // Entered and left at a negedge while the DUT sits in IDLE.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input string tag);
        logic [2*N-1:0] exp_p;
        exp_p = ref_mul(a, b);
        check({tag, " ready_before"}, ready_o, 1);
        start_i = 1'b1;
        A_i     = a;
        B_i     = b;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        A_i     = ~a;
        B_i     = ~b;
        for (int i = 0; i < N; i++) begin
            @(negedge clk_i);
            check({tag, " busy"}, {busy_o, done_o, ready_o}, 3'b100);
        end
        @(negedge clk_i);
        check({tag, " done"}, {busy_o, done_o, ready_o}, 3'b010);
        check({tag, " product"}, P_o, exp_p);
        @(negedge clk_i);
        check({tag, " ready_after"}, {busy_o, done_o, ready_o}, 3'b001);
        check({tag, " product_hold"}, P_o, exp_p);
    endtask

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        int           done_seen;

        rst_n_i = 1'b0;
        start_i = 1'b0;
        A_i     = '0;
        B_i     = '0;
        repeat (2) @(negedge clk_i);
        check("reset_flags", {busy_o, done_o, ready_o}, 3'b001);
        check("reset_product", P_o, 0);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        run_op(8'd13, 8'd11, "basic_13x11");
        run_op(8'hFF, 8'hFF, "carry_ffxff");
        run_op(8'h00, 8'hA5, "zero_a");
        run_op(8'hA5, 8'h00, "zero_b");

        // start_i held high through CALC and DONE must not queue a second request.
        check("hold_ready", ready_o, 1);
        start_i = 1'b1;
        A_i     = 8'd3;
        B_i     = 8'd5;
        @(posedge clk_i);
        #1;
        A_i = 8'd7;
        B_i = 8'd7;
        for (int i = 0; i < N; i++) begin
            @(negedge clk_i);
            check("hold_busy", {busy_o, done_o, ready_o}, 3'b100);
        end
        @(negedge clk_i);
        check("hold_done", done_o, 1);
        check("hold_first_product", P_o, ref_mul(3, 5));
        @(negedge clk_i);
        check("hold_idle", {busy_o, done_o, ready_o}, 3'b001);
        check("hold_idle_product", P_o, ref_mul(3, 5));
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        for (int i = 0; i < N; i++) begin
            @(negedge clk_i);
            check("hold2_busy", busy_o, 1);
        end
        @(negedge clk_i);
        check("hold2_done", done_o, 1);
        check("hold2_product", P_o, ref_mul(7, 7));
        @(negedge clk_i);

        // Asynchronous reset in the middle of the fourth iteration.
        start_i = 1'b1;
        A_i     = 8'd200;
        B_i     = 8'd100;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #2;
        check("abort_busy_before", busy_o, 1);
        rst_n_i = 1'b0;
        #1;
        check("abort_flags", {busy_o, done_o, ready_o}, 3'b001);
        check("abort_product", P_o, 0);
        done_seen = 0;
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk_i);
            if (i == 2) rst_n_i = 1'b1;
            if (done_o) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        check("abort_idle_product", P_o, 0);
        run_op(8'd6, 8'd7, "after_reset_6x7");

        // Back-to-back: run_op returns in the first IDLE cycle after done_o.
        run_op(8'h80, 8'h02, "b2b_80x02");

        for (int k = 0; k < 20; k++) begin
            ra = N'($urandom_range(0, 255));
            rb = N'($urandom_range(0, 255));
            run_op(ra, rb, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
